// File: rtl/ps2_keycode_decoder.sv
// PS/2 keyboard receiver (scan code set 2) feeding a held-key HID keycode.
// Input pins are synchronized and deglitched. A frame FSM collects bytes and a prefix-aware decoder maps them.
module ps2_keycode_decoder #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       PS2_CLK,
    input  logic       PS2_DATA,
    output logic [7:0] keycode,
    output logic       key_press,
    output logic       frame_err
);
    localparam int FCW = $clog2(FILTER_LEN + 1);
    localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [1:0]     clk_sync_q, dat_sync_q;
    logic           filt_q, filt_d;
    logic [FCW-1:0] filt_cnt_q, filt_cnt_d;
    logic           fall;
    logic           dat;

    state_t         state_q, state_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic [7:0]     shift_q, shift_d;
    logic           par_ok_q, par_ok_d;
    logic [TCW-1:0] tmo_q, tmo_d;
    logic           byte_valid_q, byte_valid_d;
    logic           frame_err_q, frame_err_d;

    logic           brk_q, brk_d, ext_q, ext_d;
    logic [7:0]     keycode_q, keycode_d;
    logic           key_press_q, key_press_d;
    logic [8:0]     map_res;

    // Returns {hit, hid_code} for a set-2 make code.
    function automatic logic [8:0] hid_map(input logic [7:0] sc);
        case (sc)
            8'h1C:   hid_map = {1'b1, 8'h04};
            8'h23:   hid_map = {1'b1, 8'h07};
            8'h1D:   hid_map = {1'b1, 8'h1A};
            8'h1B:   hid_map = {1'b1, 8'h16};
            8'h29:   hid_map = {1'b1, 8'h2C};
            8'h5A:   hid_map = {1'b1, 8'h28};
            8'h76:   hid_map = {1'b1, 8'h29};
            default: hid_map = 9'h000;
        endcase
    endfunction

    assign dat = dat_sync_q[1];

    always_comb begin
        filt_d     = filt_q;
        filt_cnt_d = '0;
        if (clk_sync_q[1] != filt_q) begin
            if (filt_cnt_q == FCW'(FILTER_LEN - 1)) begin
                filt_d = clk_sync_q[1];
            end else begin
                filt_cnt_d = filt_cnt_q + 1'b1;
            end
        end
    end

    assign fall = filt_q & ~filt_d;

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        par_ok_d     = par_ok_q;
        tmo_d        = '0;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        if (state_q == IDLE) begin
            if (fall) begin
                if (!dat) begin
                    state_d   = DATA;
                    bit_cnt_d = 3'd0;
                end else begin
                    frame_err_d = 1'b1;
                end
            end
        end else if (fall) begin
            case (state_q)
                DATA: begin
                    shift_d   = {dat, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = PARITY;
                end
                PARITY: begin
                    par_ok_d = ^{shift_q, dat};
                    state_d  = STOP;
                end
                default: begin
                    if (dat && par_ok_q) byte_valid_d = 1'b1;
                    else                 frame_err_d  = 1'b1;
                    state_d = IDLE;
                end
            endcase
        end else if (tmo_q == TCW'(TIMEOUT_CYCLES - 1)) begin
            frame_err_d = 1'b1;
            state_d     = IDLE;
        end else begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    assign map_res = hid_map(shift_q);

    always_comb begin
        brk_d       = brk_q;
        ext_d       = ext_q;
        keycode_d   = keycode_q;
        key_press_d = 1'b0;
        if (frame_err_q) begin
            brk_d = 1'b0;
            ext_d = 1'b0;
        end else if (byte_valid_q) begin
            if (shift_q == 8'hF0) begin
                brk_d = 1'b1;
            end else if (shift_q == 8'hE0) begin
                ext_d = 1'b1;
            end else begin
                brk_d = 1'b0;
                ext_d = 1'b0;
                // Extended keys share make codes with mapped keys, so they are dropped.
                if (!ext_q && map_res[8]) begin
                    if (brk_q) begin
                        if (map_res[7:0] == keycode_q) keycode_d = 8'h00;
                    end else if (map_res[7:0] != keycode_q) begin
                        keycode_d   = map_res[7:0];
                        key_press_d = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            clk_sync_q   <= 2'b11;
            dat_sync_q   <= 2'b11;
            filt_q       <= 1'b1;
            filt_cnt_q   <= '0;
            state_q      <= IDLE;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'h00;
            par_ok_q     <= 1'b0;
            tmo_q        <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            brk_q        <= 1'b0;
            ext_q        <= 1'b0;
            keycode_q    <= 8'h00;
            key_press_q  <= 1'b0;
        end else begin
            clk_sync_q   <= {clk_sync_q[0], PS2_CLK};
            dat_sync_q   <= {dat_sync_q[0], PS2_DATA};
            filt_q       <= filt_d;
            filt_cnt_q   <= filt_cnt_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_ok_q     <= par_ok_d;
            tmo_q        <= tmo_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
            brk_q        <= brk_d;
            ext_q        <= ext_d;
            keycode_q    <= keycode_d;
            key_press_q  <= key_press_d;
        end
    end

    assign keycode   = keycode_q;
    assign key_press = key_press_q;
    assign frame_err = frame_err_q;
endmodule
